uart_rx_pack_ctrl: RTL and testbench

- Sequencer for the UART RX 8-to-24 packer (`uart_reg8to24`).
- Takes the raw RX byte stream and drives the packer's `wren`/`din`/`rden`.
- Decides when to flush a word: 3 bytes collected, idle timeout, or forced flush.
- Pushes `{valid_bytes, dout}` into the downstream RX FIFO and handles FIFO backpressure with a one-byte skid buffer.

---
 rtl/uart_rx_pack_pkg.sv | 6 +
 rtl/uart_idle_timer.sv | 17 +
 rtl/uart_rx_pack_ctrl.sv | 86 ++++++++
 tb/tb_uart_rx_pack_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pack_pkg.sv
// uart_rx_pack_pkg: shared types and constants for the UART RX packer controller.
package uart_rx_pack_pkg;
  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;
  localparam int WORD_BYTES = 3;
  localparam int FIFO_W = 34;
endpackage

// File: rtl/uart_idle_timer.sv
// uart_idle_timer: idle counter that expires on the cycle it would reach TIMEOUT_CYCLES-1.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] t;
  always_ff @(posedge clk)
    if (rst || clr) t <= '0;
    else if (en) t <= t + W'(1);
  assign expire = en && t == W'(TIMEOUT_CYCLES - 2);
endmodule

// File: rtl/uart_rx_pack_ctrl.sv
// uart_rx_pack_ctrl: sequences RX bytes into the 8-to-24 packer and flushes words to the RX FIFO.
// Defining UART_RX_PACK_STATS_EN adds saturating words_out/bytes_dropped counters.
module uart_rx_pack_ctrl
  import uart_rx_pack_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int FIFO_W = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              flush_req,
  output logic              pk_wren,
  output logic [7:0]        pk_din,
  output logic              pk_rden,
  input  logic [31:0]       pk_dout,
  input  logic [1:0]        pk_valid_bytes,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [FIFO_W-1:0] fifo_data,
  input  logic              clr_overflow,
  output logic              overflow
`ifdef UART_RX_PACK_STATS_EN
  ,
  output logic [15:0]       words_out,
  output logic [15:0]       bytes_dropped
`endif
);
  state_t state, state_n;
  logic [1:0] cnt, cnt_inc;
  logic skid_v;
  logic [7:0] skid_d, src;
  logic take, drop, expire;
  uart_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != FILL || take),
    .en     (state == FILL && !take),
    .expire (expire)
  );
  // pk_wren is registered, so a FLUSH entered with a write still in flight waits one cycle for pk_dout to settle
  always_comb begin
    src = skid_v ? skid_d : rx_data;
    take = state != FLUSH && (skid_v || rx_valid);
    cnt_inc = cnt + 2'd1;
    fifo_wr = state == FLUSH && !fifo_full && !pk_wren;
    pk_rden = fifo_wr;
    fifo_data = {pk_valid_bytes, pk_dout};
    drop = state == FLUSH && rx_valid && skid_v;
    state_n = state;
    case (state)
      IDLE:    state_n = take ? FILL : IDLE;
      FILL:    state_n = (take && cnt_inc == 2'(WORD_BYTES)) || flush_req || expire ? FLUSH : FILL;
      default: state_n = fifo_wr ? IDLE : FLUSH;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      skid_v <= 1'b0;
      skid_d <= 8'd0;
      pk_wren <= 1'b0;
      pk_din <= 8'd0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= fifo_wr ? 2'd0 : take ? cnt_inc : cnt;
      skid_v <= take ? skid_v && rx_valid : skid_v || rx_valid;
      if (rx_valid && (take ? skid_v : !skid_v)) skid_d <= rx_data;
      pk_wren <= take;
      if (take) pk_din <= src;
      overflow <= drop || (overflow && !clr_overflow);
    end
`ifdef UART_RX_PACK_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      words_out <= 16'd0;
      bytes_dropped <= 16'd0;
    end else begin
      if (fifo_wr && words_out != 16'hffff) words_out <= words_out + 16'd1;
      if (drop && bytes_dropped != 16'hffff) bytes_dropped <= bytes_dropped + 16'd1;
    end
`endif
endmodule

// File: tb/tb_uart_rx_pack_ctrl.sv
// tb_uart_rx_pack_ctrl: directed and randomized checks of the packer controller against a byte-order scoreboard.
module tb_uart_rx_pack_ctrl;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst, rx_valid, flush_req, fifo_full, clr_overflow;
  logic [7:0] rx_data, pk_din;
  logic pk_wren, pk_rden, fifo_wr, overflow;
  logic [31:0] pk_dout;
  logic [1:0] pk_valid_bytes;
  logic [33:0] fifo_data;
`ifdef UART_RX_PACK_STATS_EN
  logic [15:0] words_out, bytes_dropped;
`endif
  int n_chk = 0, n_err = 0, cyc = 0, n_words = 0, last_vb = 0, c0;
  int wr_cyc[$];
  logic [7:0] exp_q[$];
  logic [23:0] pk_buf;
  int pk_n = 0;

  uart_rx_pack_ctrl #(.TIMEOUT_CYCLES(TO), .FIFO_W(34)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .flush_req(flush_req),
    .pk_wren(pk_wren), .pk_din(pk_din), .pk_rden(pk_rden), .pk_dout(pk_dout),
    .pk_valid_bytes(pk_valid_bytes), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .clr_overflow(clr_overflow), .overflow(overflow)
`ifdef UART_RX_PACK_STATS_EN
    , .words_out(words_out), .bytes_dropped(bytes_dropped)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // packer model: first byte lands in dout[7:0]
  always @(posedge clk)
    if (rst || pk_rden) begin
      pk_buf <= 24'd0;
      pk_n <= 0;
    end else if (pk_wren && pk_n < 3) begin
      pk_buf[8*pk_n +: 8] <= pk_din;
      pk_n <= pk_n + 1;
    end
  assign pk_dout = {8'h00, pk_buf};
  assign pk_valid_bytes = 2'(pk_n);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      check("wren_rden_excl", pk_wren & pk_rden, 0);
      if (fifo_wr) begin
        wr_cyc.push_back(cyc);
        n_words++;
        last_vb = int'(fifo_data[33:32]);
        check("rden_with_wr", pk_rden, 1);
        check("wr_while_full", fifo_full, 0);
        check("vb_nonzero", last_vb != 0, 1);
        for (int i = 0; i < last_vb; i++)
          if (exp_q.size() == 0) check("extra_byte", fifo_data[8*i +: 8], 9'h100);
          else check("word_byte", fifo_data[8*i +: 8], exp_q.pop_front());
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    rx_valid = 1'b1;
    rx_data = b;
    if (keep) exp_q.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic int first_wr(input int k);
    return wr_cyc.size() > k ? wr_cyc[k] : -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; flush_req = 1'b0;
    fifo_full = 1'b0; clr_overflow = 1'b0;
    idle(3);
    check("rst_wren", pk_wren, 0);
    check("rst_din", pk_din, 0);
    check("rst_ovf", overflow, 0);
    check("rst_fifo_wr", fifo_wr, 0);
    rst = 1'b0;
    idle(2);
    // three back-to-back bytes: word goes out one cycle after the last packer write
    wr_cyc.delete(); c0 = cyc;
    send(8'hAB, 1); send(8'h01, 1); send(8'hEF, 1);
    check("ef_wren", pk_wren, 1);
    check("ef_din", pk_din, 8'hEF);
    idle(6);
    check("full_word_count", wr_cyc.size(), 1);
    check("full_word_cycle", first_wr(0), c0 + 4);
    check("full_word_vb", last_vb, 3);
    // single byte then silence
    wr_cyc.delete(); c0 = cyc;
    send(8'h55, 1);
    idle(TO + 4);
    check("timeout_count", wr_cyc.size(), 1);
    check("timeout_cycle", first_wr(0), c0 + TO);
    check("timeout_vb", last_vb, 1);
    // forced flush of two bytes, then flush in IDLE does nothing
    wr_cyc.delete(); c0 = cyc;
    send(8'h01, 1); send(8'h02, 1); tick();
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    idle(3);
    check("flush_cycle", first_wr(0), c0 + 4);
    check("flush_vb", last_vb, 2);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    idle(5);
    check("idle_flush_ignored", wr_cyc.size(), 1);
    // backpressure: skid holds one byte, further bytes drop
    fifo_full = 1'b1; wr_cyc.delete(); c0 = cyc;
    send(8'hA0, 1); send(8'hA1, 1); send(8'hA2, 1);
    send(8'h10, 1); send(8'h11, 0); send(8'h12, 0);
    check("ovf_set", overflow, 1);
    idle(2);
    check("no_wr_while_full", wr_cyc.size(), 0);
    fifo_full = 1'b0;
    idle(2);
    check("skid_wren", pk_wren, 1);
    check("skid_din", pk_din, 8'h10);
    tick();
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    idle(3);
    check("bp_word_cycle", first_wr(0), c0 + 8);
    check("skid_word_cycle", first_wr(1), c0 + 12);
    check("skid_word_vb", last_vb, 1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("ovf_clr", overflow, 0);
    // drop coincident with clear keeps overflow set
    fifo_full = 1'b1;
    send(8'hB0, 1); send(8'hB1, 1); send(8'hB2, 1); send(8'h20, 1);
    clr_overflow = 1'b1; send(8'h21, 0); clr_overflow = 1'b0;
    check("ovf_drop_wins", overflow, 1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("ovf_clr2", overflow, 0);
    fifo_full = 1'b0;
    idle(TO + 6);
    check("drained", exp_q.size(), 0);
    // reset mid-word discards the partial word
    send(8'hC0, 0); send(8'hC1, 0);
    rst = 1'b1; tick();
    check("mid_rst_wren", pk_wren, 0);
    check("mid_rst_din", pk_din, 0);
    check("mid_rst_fifo_wr", fifo_wr, 0);
    check("mid_rst_rden", pk_rden, 0);
    rst = 1'b0; wr_cyc.delete();
    idle(TO + 4);
    check("mid_rst_no_wr", wr_cyc.size(), 0);
    send(8'hD0, 1); send(8'hD1, 1); send(8'hD2, 1);
    idle(5);
    check("post_rst_count", wr_cyc.size(), 1);
    check("post_rst_vb", last_vb, 3);
    // randomized stream: every accepted byte must emerge once, in order
    repeat (60) begin
      automatic int gap = $urandom_range(2, 20);
      flush_req = ($urandom_range(0, 7) == 0);
      send(8'($urandom), 1);
      flush_req = 1'b0;
      repeat (gap - 1) begin
        flush_req = ($urandom_range(0, 7) == 0);
        tick();
      end
      flush_req = 1'b0;
    end
    idle(TO + 8);
    check("rand_drained", exp_q.size(), 0);
    check("rand_no_ovf", overflow, 0);
`ifdef UART_RX_PACK_STATS_EN
    check("words_out", words_out, n_words);
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
